mem_access_arbiter: RTL and testbench

//  Shares the single-port 2048-word data memory between the CPU data port and a DMA/VGA port.
//  - Round-robin arbitration between the two requesters.
//  - Decodes each 32-bit virtual address into an 11-bit physical word index.
//  - Sequences one memory access per grant with a registered req/ack handshake.
//  - Rejects out-of-range or misaligned addresses with an error ack; no memory cycle is issued.

---
 rtl/mem_access_arbiter_if.sv | 29 ++
 rtl/mem_access_arbiter.sv | 114 +++++++++++
 tb/tb_mem_access_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// Request/response bundle between the CPU and DMA masters, the memory arbiter and the data memory.
// The slave view is the arbiter; the master view is everything around it.
interface mem_access_arbiter_if;
    logic        cpuReq, cpuWe, cpuAck, cpuErr;
    logic [31:0] cpuAddr, cpuWdata, cpuRdata;
    logic        dmaReq, dmaWe, dmaAck, dmaErr;
    logic [31:0] dmaAddr, dmaWdata, dmaRdata;
    logic        memEn, memWe;
    logic [10:0] memAddr;
    logic [31:0] memWdata, memRdata;

    modport slave (
        input  cpuReq, cpuWe, cpuAddr, cpuWdata,
        input  dmaReq, dmaWe, dmaAddr, dmaWdata,
        input  memRdata,
        output cpuAck, cpuErr, cpuRdata,
        output dmaAck, dmaErr, dmaRdata,
        output memEn, memWe, memAddr, memWdata
    );

    modport master (
        output cpuReq, cpuWe, cpuAddr, cpuWdata,
        output dmaReq, dmaWe, dmaAddr, dmaWdata,
        output memRdata,
        input  cpuAck, cpuErr, cpuRdata,
        input  dmaAck, dmaErr, dmaRdata,
        input  memEn, memWe, memAddr, memWdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin CPU/DMA arbiter in front of the single-port 2048-word data memory, with address decode and fault acks.
// Optional sticky fault capture (faultClr/faultValid/faultAddr/faultSrc) when MEM_ARB_FAULT_LATCH_EN is defined.
module mem_access_arbiter #(
    parameter logic [31:0] DATA_BASE  = 32'h10010000,
    parameter logic [31:0] STACK_BASE = 32'hEFFFF000,
    parameter logic [31:0] SEG_BYTES  = 32'h1000
) (
    input  logic clk,
    input  logic rst_n,
    mem_access_arbiter_if.slave bus
`ifdef MEM_ARB_FAULT_LATCH_EN
    ,
    input  logic        faultClr,
    output logic        faultValid,
    output logic [31:0] faultAddr,
    output logic        faultSrc
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t      state, stateNxt;
    logic        lastGrant;   // 0 = CPU, 1 = DMA
    logic        winner;
    logic        weQ;
    logic [31:0] wdataQ;
    logic [10:0] addrQ;
    logic [31:0] cpuRdataQ, dmaRdataQ;

    logic        anyReq, grantDma, hitData, hitStack, fault;
    logic [31:0] selAddr, offData, offStack;
    logic [10:0] physAddr;

    // Arbitration and decode only matter in IDLE, where the request is sampled.
    always_comb begin
        anyReq   = bus.cpuReq || bus.dmaReq;
        grantDma = bus.dmaReq && (!bus.cpuReq || !lastGrant);
        selAddr  = grantDma ? bus.dmaAddr : bus.cpuAddr;
        offData  = selAddr - DATA_BASE;
        offStack = selAddr - STACK_BASE;
        hitData  = offData < SEG_BYTES;
        hitStack = offStack < SEG_BYTES;
        fault    = !(hitData || hitStack) || (selAddr[1:0] != 2'b00);
        physAddr = hitData ? {1'b0, offData[11:2]} : {1'b1, offStack[11:2]};
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:     if (anyReq) stateNxt = fault ? ERR : ACCESS;
            ACCESS:   stateNxt = RESP;
            RESP:     stateNxt = IDLE;
            ERR:      stateNxt = IDLE;
            default:  stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            winner    <= 1'b0;
            weQ       <= 1'b0;
            wdataQ    <= '0;
            addrQ     <= '0;
            cpuRdataQ <= '0;
            dmaRdataQ <= '0;
        end else begin
            state <= stateNxt;
            if (state == IDLE && anyReq) begin
                winner    <= grantDma;
                lastGrant <= grantDma;
                weQ       <= grantDma ? bus.dmaWe : bus.cpuWe;
                wdataQ    <= grantDma ? bus.dmaWdata : bus.cpuWdata;
                addrQ     <= physAddr;
            end
            if (state == RESP && !weQ) begin
                if (winner) dmaRdataQ <= bus.memRdata;
                else        cpuRdataQ <= bus.memRdata;
            end
        end
    end

    // Read data is forwarded straight from the memory during RESP so it is valid alongside the ack.
    assign bus.memEn    = (state == ACCESS);
    assign bus.memWe    = (state == ACCESS) && weQ;
    assign bus.memAddr  = addrQ;
    assign bus.memWdata = wdataQ;
    assign bus.cpuAck   = (state == RESP || state == ERR) && !winner;
    assign bus.cpuErr   = (state == ERR) && !winner;
    assign bus.dmaAck   = (state == RESP || state == ERR) && winner;
    assign bus.dmaErr   = (state == ERR) && winner;
    assign bus.cpuRdata = (state == RESP && !winner && !weQ) ? bus.memRdata : cpuRdataQ;
    assign bus.dmaRdata = (state == RESP && winner && !weQ) ? bus.memRdata : dmaRdataQ;

`ifdef MEM_ARB_FAULT_LATCH_EN
    logic faultEvent;
    assign faultEvent = (state == IDLE) && anyReq && fault;

    // A fault arriving with faultClr wins, so no fault is ever lost to a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            faultValid <= 1'b0;
            faultAddr  <= '0;
            faultSrc   <= 1'b0;
        end else if (faultEvent && (!faultValid || faultClr)) begin
            faultValid <= 1'b1;
            faultAddr  <= selAddr;
            faultSrc   <= grantDma;
        end else if (faultClr) begin
            faultValid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized rounds against a
// behavioural model (address map arithmetic, round-robin order, reference memory image).
module tb_mem_access_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_access_arbiter_if bus();

`ifdef MEM_ARB_FAULT_LATCH_EN
    logic        faultClr = 1'b0;
    logic        faultValid, faultSrc;
    logic [31:0] faultAddr;
`endif

    mem_access_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef MEM_ARB_FAULT_LATCH_EN
        ,
        .faultClr(faultClr),
        .faultValid(faultValid),
        .faultAddr(faultAddr),
        .faultSrc(faultSrc)
`endif
    );

    // Data memory macro model: one-cycle read latency.
    logic [31:0] mem [2048];
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'(i) * 32'h9E3779B9 + 32'h5A5A0001;
        mem[2] = 32'hDEADBEEF;
    end
    always @(posedge clk) begin
        if (bus.memEn) begin
            if (bus.memWe) mem[bus.memAddr] <= bus.memWdata;
            else           bus.memRdata <= mem[bus.memAddr];
        end
    end

    logic [31:0] refMem [2048];
    logic [31:0] rdModel [2];
    bit          lastModel;
    int          nCmp = 0;
    int          nBad = 0;

    function automatic void refDecode(input logic [31:0] a, output bit f, output logic [10:0] idx);
        longint unsigned ua;
        ua  = 64'(a);
        f   = 1'b1;
        idx = '0;
        if (a % 4 == 0) begin
            if (ua >= 64'h10010000 && ua < 64'h10011000) begin
                f = 1'b0; idx = 11'((ua - 64'h10010000) / 4);
            end else if (ua >= 64'hEFFFF000 && ua < 64'hF0000000) begin
                f = 1'b0; idx = 11'(1024 + (ua - 64'hEFFFF000) / 4);
            end
        end
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] pool [6];
        int sel;
        pool = '{32'h10010FFC, 32'h10011000, 32'hEFFFFFFC, 32'hEFFFEFFC, 32'h1000FFFC, 32'hF0000000};
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: return 32'h10010000 + 32'($urandom_range(0, 1023)) * 4;
            3, 4, 5: return 32'hEFFFF000 + 32'($urandom_range(0, 1023)) * 4;
            6, 7:    return pool[$urandom_range(0, 5)];
            8:       return (32'h10010000 + 32'($urandom_range(0, 4095))) | 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic idleInputs();
        bus.cpuReq = 0; bus.cpuWe = 0; bus.cpuAddr = '0; bus.cpuWdata = '0;
        bus.dmaReq = 0; bus.dmaWe = 0; bus.dmaAddr = '0; bus.dmaWdata = '0;
    endtask

    task automatic test_reset();
        idleInputs();
        #2 rst_n = 1'b0;
        #1;
        nCmp++; if ({bus.cpuAck, bus.cpuErr, bus.dmaAck, bus.dmaErr, bus.memEn, bus.memWe} !== 6'b0) begin
            nBad++; $display("FAIL reset_ctrl: got %b want 000000", {bus.cpuAck, bus.cpuErr, bus.dmaAck, bus.dmaErr, bus.memEn, bus.memWe}); end
        nCmp++; if ({bus.cpuRdata, bus.dmaRdata} !== 64'h0) begin
            nBad++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.cpuRdata, bus.dmaRdata); end
        nCmp++; if ({bus.memAddr, bus.memWdata} !== 43'h0) begin
            nBad++; $display("FAIL reset_membus: got %h/%h want 0/0", bus.memAddr, bus.memWdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lastModel = 1'b1; rdModel[0] = '0; rdModel[1] = '0;
    endtask

    task automatic test_cpu_read();
        @(negedge clk); bus.cpuReq = 1; bus.cpuWe = 0; bus.cpuAddr = 32'h10010008;
        @(negedge clk);
        nCmp++; if ({bus.memEn, bus.memWe, bus.memAddr} !== {1'b1, 1'b0, 11'h002}) begin
            nBad++; $display("FAIL cpu_read_mem: got en/we/addr %b/%b/%h want 1/0/002", bus.memEn, bus.memWe, bus.memAddr); end
        nCmp++; if (bus.cpuAck !== 1'b0) begin nBad++; $display("FAIL cpu_read_early_ack: got %b want 0", bus.cpuAck); end
        @(negedge clk);
        nCmp++; if ({bus.cpuAck, bus.cpuErr, bus.dmaAck, bus.memEn} !== 4'b1000) begin
            nBad++; $display("FAIL cpu_read_ack: got ack/err/dack/en %b want 1000", {bus.cpuAck, bus.cpuErr, bus.dmaAck, bus.memEn}); end
        nCmp++; if (bus.cpuRdata !== 32'hDEADBEEF) begin nBad++; $display("FAIL cpu_read_data: got %h want deadbeef", bus.cpuRdata); end
        @(negedge clk); bus.cpuReq = 0;
        lastModel = 1'b0; rdModel[0] = 32'hDEADBEEF;
    endtask

    task automatic test_dma_write();
        @(negedge clk); bus.dmaReq = 1; bus.dmaWe = 1; bus.dmaAddr = 32'hEFFFF004; bus.dmaWdata = 32'h12345678;
        @(negedge clk);
        nCmp++; if ({bus.memEn, bus.memWe, bus.memAddr, bus.memWdata} !== {1'b1, 1'b1, 11'h401, 32'h12345678}) begin
            nBad++; $display("FAIL dma_write_mem: got en/we/addr/data %b/%b/%h/%h want 1/1/401/12345678", bus.memEn, bus.memWe, bus.memAddr, bus.memWdata); end
        @(negedge clk);
        nCmp++; if ({bus.dmaAck, bus.dmaErr, bus.cpuAck, bus.memEn} !== 4'b1000) begin
            nBad++; $display("FAIL dma_write_ack: got ack/err/cack/en %b want 1000", {bus.dmaAck, bus.dmaErr, bus.cpuAck, bus.memEn}); end
        nCmp++; if ({bus.cpuRdata, bus.dmaRdata} !== {rdModel[0], rdModel[1]}) begin
            nBad++; $display("FAIL dma_write_rdata: got %h/%h want %h/%h", bus.cpuRdata, bus.dmaRdata, rdModel[0], rdModel[1]); end
        @(negedge clk); bus.dmaReq = 0; bus.dmaWe = 0;
        lastModel = 1'b1; refMem[11'h401] = 32'h12345678;
    endtask

    task automatic test_fault_reads();
        logic [31:0] addrs [2];
        addrs = '{32'h10011000, 32'h10010002};
        @(negedge clk); bus.cpuReq = 1; bus.cpuWe = 0;
        for (int k = 0; k < 2; k++) begin
            bus.cpuAddr = addrs[k];
            @(negedge clk);
            nCmp++; if ({bus.cpuAck, bus.cpuErr, bus.memEn} !== 3'b110) begin
                nBad++; $display("FAIL fault_ack_%0d: got ack/err/en %b want 110", k, {bus.cpuAck, bus.cpuErr, bus.memEn}); end
            nCmp++; if (bus.cpuRdata !== rdModel[0]) begin
                nBad++; $display("FAIL fault_rdata_%0d: got %h want %h", k, bus.cpuRdata, rdModel[0]); end
            @(negedge clk);
            nCmp++; if ({bus.cpuAck, bus.memEn} !== 2'b00) begin
                nBad++; $display("FAIL fault_idle_%0d: got ack/en %b want 00", k, {bus.cpuAck, bus.memEn}); end
        end
        bus.cpuReq = 0;
        lastModel = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit expC, expD, expEn;
        @(negedge clk);
        rst_n = 1'b0;
        bus.cpuReq = 1; bus.cpuWe = 0; bus.cpuAddr = 32'h10010000;
        bus.dmaReq = 1; bus.dmaWe = 0; bus.dmaAddr = 32'hEFFFF000;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            expC = (i == 2 || i == 8); expD = (i == 5 || i == 11); expEn = (i % 3 == 1);
            nCmp++; if ({bus.cpuAck, bus.dmaAck, bus.memEn} !== {expC, expD, expEn}) begin
                nBad++; $display("FAIL b2b_cycle_%0d: got cack/dack/en %b want %b", i, {bus.cpuAck, bus.dmaAck, bus.memEn}, {expC, expD, expEn}); end
            if (expC) begin nCmp++; if (bus.cpuRdata !== refMem[0]) begin
                nBad++; $display("FAIL b2b_cpu_data_%0d: got %h want %h", i, bus.cpuRdata, refMem[0]); end end
            if (expD) begin nCmp++; if (bus.dmaRdata !== refMem[1024]) begin
                nBad++; $display("FAIL b2b_dma_data_%0d: got %h want %h", i, bus.dmaRdata, refMem[1024]); end end
        end
        idleInputs();
        lastModel = 1'b1; rdModel[0] = refMem[0]; rdModel[1] = refMem[1024];
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk); bus.cpuReq = 1; bus.cpuWe = 0; bus.cpuAddr = 32'h10010010;
        @(negedge clk);
        nCmp++; if (bus.memEn !== 1'b1) begin nBad++; $display("FAIL rst_mid_pre_en: got %b want 1", bus.memEn); end
        #1 rst_n = 1'b0;
        #1;
        nCmp++; if ({bus.cpuAck, bus.cpuErr, bus.dmaAck, bus.dmaErr, bus.memEn, bus.memWe, bus.memAddr, bus.cpuRdata, bus.dmaRdata} !== '0) begin
            nBad++; $display("FAIL rst_mid_outputs: got en/addr/crd/drd %b/%h/%h/%h want all zero", bus.memEn, bus.memAddr, bus.cpuRdata, bus.dmaRdata); end
        lastModel = 1'b1; rdModel[0] = '0; rdModel[1] = '0;
        repeat (2) begin
            @(negedge clk);
            nCmp++; if ({bus.cpuAck, bus.memEn} !== 2'b00) begin
                nBad++; $display("FAIL rst_mid_held: got ack/en %b want 00", {bus.cpuAck, bus.memEn}); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        nCmp++; if ({bus.memEn, bus.memAddr} !== {1'b1, 11'h004}) begin
            nBad++; $display("FAIL rst_mid_restart: got en/addr %b/%h want 1/004", bus.memEn, bus.memAddr); end
        @(negedge clk);
        nCmp++; if ({bus.cpuAck, bus.cpuErr, bus.cpuRdata} !== {1'b1, 1'b0, refMem[4]}) begin
            nBad++; $display("FAIL rst_mid_complete: got ack/err/data %b/%b/%h want 1/0/%h", bus.cpuAck, bus.cpuErr, bus.cpuRdata, refMem[4]); end
        @(negedge clk); bus.cpuReq = 0;
        lastModel = 1'b0; rdModel[0] = refMem[4];
    endtask

    task automatic test_random();
        logic [31:0] a [2];
        logic [31:0] d [2];
        bit          w [2];
        bit          ord [2];
        bit          p, f;
        int          n, sel;
        logic [10:0] idx;
        for (int r = 0; r < 60; r++) begin
            @(negedge clk);
            sel = $urandom_range(1, 3);
            for (int q = 0; q < 2; q++) begin a[q] = randAddr(); w[q] = 1'($urandom_range(0, 1)); d[q] = $urandom; end
            bus.cpuReq = sel[0]; bus.cpuAddr = a[0]; bus.cpuWe = w[0]; bus.cpuWdata = d[0];
            bus.dmaReq = sel[1]; bus.dmaAddr = a[1]; bus.dmaWe = w[1]; bus.dmaWdata = d[1];
            if (sel == 3) begin ord[0] = !lastModel; ord[1] = lastModel; n = 2; end
            else begin ord[0] = sel[1]; ord[1] = 1'b0; n = 1; end
            for (int k = 0; k < n; k++) begin
                p = ord[k];
                refDecode(a[p], f, idx);
                lastModel = p;
                @(negedge clk);
                if (f) begin
                    nCmp++; if ({p ? bus.dmaAck : bus.cpuAck, p ? bus.dmaErr : bus.cpuErr, p ? bus.cpuAck : bus.dmaAck, bus.memEn} !== 4'b1100) begin
                        nBad++; $display("FAIL rnd%0d_fault_ack port%0d addr %h: got cack/cerr/dack/derr/en %b want winner ack+err only", r, p, a[p], {bus.cpuAck, bus.cpuErr, bus.dmaAck, bus.dmaErr, bus.memEn}); end
                end else begin
                    nCmp++; if ({bus.memEn, bus.memWe, bus.memAddr} !== {1'b1, w[p], idx}) begin
                        nBad++; $display("FAIL rnd%0d_mem port%0d addr %h: got en/we/idx %b/%b/%h want 1/%b/%h", r, p, a[p], bus.memEn, bus.memWe, bus.memAddr, w[p], idx); end
                    if (w[p]) begin
                        nCmp++; if (bus.memWdata !== d[p]) begin
                            nBad++; $display("FAIL rnd%0d_wdata: got %h want %h", r, bus.memWdata, d[p]); end
                        refMem[idx] = d[p];
                    end
                    @(negedge clk);
                    if (!w[p]) rdModel[p] = refMem[idx];
                    nCmp++; if ({p ? bus.dmaAck : bus.cpuAck, p ? bus.dmaErr : bus.cpuErr, p ? bus.cpuAck : bus.dmaAck, bus.memEn} !== 4'b1000) begin
                        nBad++; $display("FAIL rnd%0d_ack port%0d: got cack/cerr/dack/derr/en %b want winner ack only", r, p, {bus.cpuAck, bus.cpuErr, bus.dmaAck, bus.dmaErr, bus.memEn}); end
                end
                nCmp++; if ({bus.cpuRdata, bus.dmaRdata} !== {rdModel[0], rdModel[1]}) begin
                    nBad++; $display("FAIL rnd%0d_rdata: got %h/%h want %h/%h", r, bus.cpuRdata, bus.dmaRdata, rdModel[0], rdModel[1]); end
                @(negedge clk);
                nCmp++; if ({bus.cpuAck, bus.dmaAck, bus.memEn} !== 3'b000) begin
                    nBad++; $display("FAIL rnd%0d_idle: got cack/dack/en %b want 000", r, {bus.cpuAck, bus.dmaAck, bus.memEn}); end
                if (p) bus.dmaReq = 0; else bus.cpuReq = 0;
            end
        end
        idleInputs();
    endtask

`ifdef MEM_ARB_FAULT_LATCH_EN
    task automatic test_fault_latch();
        @(negedge clk); faultClr = 1;
        @(negedge clk); faultClr = 0;
        nCmp++; if (faultValid !== 1'b0) begin nBad++; $display("FAIL flt_clear0: got %b want 0", faultValid); end
        bus.cpuReq = 1; bus.cpuAddr = 32'h00000000;
        @(negedge clk);
        nCmp++; if ({faultValid, faultAddr, faultSrc} !== {1'b1, 32'h0, 1'b0}) begin
            nBad++; $display("FAIL flt_first: got v/addr/src %b/%h/%b want 1/00000000/0", faultValid, faultAddr, faultSrc); end
        @(negedge clk); bus.cpuReq = 0; bus.dmaReq = 1; bus.dmaAddr = 32'h20000000;
        @(negedge clk);
        nCmp++; if ({faultValid, faultAddr, faultSrc} !== {1'b1, 32'h0, 1'b0}) begin
            nBad++; $display("FAIL flt_hold: got v/addr/src %b/%h/%b want 1/00000000/0", faultValid, faultAddr, faultSrc); end
        @(negedge clk); bus.dmaReq = 0; faultClr = 1;
        @(negedge clk); faultClr = 0;
        nCmp++; if (faultValid !== 1'b0) begin nBad++; $display("FAIL flt_clear: got %b want 0", faultValid); end
        bus.dmaReq = 1;
        @(negedge clk);
        nCmp++; if ({faultValid, faultAddr, faultSrc} !== {1'b1, 32'h20000000, 1'b1}) begin
            nBad++; $display("FAIL flt_dma: got v/addr/src %b/%h/%b want 1/20000000/1", faultValid, faultAddr, faultSrc); end
        @(negedge clk); bus.dmaReq = 0; bus.cpuReq = 1; bus.cpuAddr = 32'h30000004; faultClr = 1;
        @(negedge clk); faultClr = 0;
        nCmp++; if ({faultValid, faultAddr, faultSrc} !== {1'b1, 32'h30000004, 1'b0}) begin
            nBad++; $display("FAIL flt_clr_and_new: got v/addr/src %b/%h/%b want 1/30000004/0", faultValid, faultAddr, faultSrc); end
        @(negedge clk); bus.cpuReq = 0;
        lastModel = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) refMem[i] = 32'(i) * 32'h9E3779B9 + 32'h5A5A0001;
        refMem[2] = 32'hDEADBEEF;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_fault_reads();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
`ifdef MEM_ARB_FAULT_LATCH_EN
        test_fault_latch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
